// File: rtl/data_memory_stage_pkg.sv
// Shared encodings for the MEM-stage data memory: access size/direction codes,
// FSM state type and the load-data extension helper.
package data_memory_stage_pkg;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic RW_LOAD   = 1'b0;
    localparam logic RW_STORE  = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // The array always returns the big-endian word at A; a byte load keeps only Mem[A].
    function automatic logic [31:0] load_extend(input logic size, input logic [31:0] word);
        if (size == SIZE_WORD) begin
            return word;
        end
        return {24'h000000, word[31:24]};
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-addressed storage: synchronous byte/word write and asynchronous big-endian
// word read, both wrapping modulo the array depth.
module data_mem_array
    import data_memory_stage_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_size,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_word
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem_q [0:DEPTH-1];

    // Contents are deliberately not reset; a word store lands MSB-first at A..A+3.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_size == SIZE_WORD) begin
                for (int k = 0; k < 4; k++) begin
                    mem_q[wr_addr + ADDR_W'(k)] <= wr_data[31-8*k -: 8];
                end
            end else begin
                mem_q[wr_addr] <= wr_data[7:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_word[31-8*gi -: 8] = mem_q[rd_addr + ADDR_W'(gi)];
        end
    endgenerate

endmodule

// File: rtl/data_memory_stage.sv
// MEM-stage data memory with configurable access latency; holds the pipeline via
// Stall while a multi-cycle access is in flight.
module data_memory_stage
    import data_memory_stage_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic              Clk,
    input  logic              Clr_n,
    input  logic              MEM_E,
    input  logic              MEM_RW,
    input  logic              MEM_Size,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              Stall,
    output logic              Busy
);

    localparam int             CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              size_q;
    logic              rw_q;

    logic              stall_c;
    logic              complete_c;
    logic              latch_c;
    logic              in_access;
    logic [ADDR_W-1:0] eff_addr;
    logic [31:0]       eff_data;
    logic              eff_size;
    logic              eff_rw;
    logic              wr_en;
    logic [31:0]       rd_word;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_c    = 1'b0;
        complete_c = 1'b0;
        latch_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MEM_E) begin
                    if (LATENCY == 1) begin
                        complete_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        latch_c = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    complete_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Once accepted, the request is served from the latched copy, so upstream
    // changes during the stall cannot corrupt it.
    assign in_access = (state_q == ST_ACCESS);
    assign eff_addr  = in_access ? addr_q : Address;
    assign eff_data  = in_access ? data_q : DataIn;
    assign eff_size  = in_access ? size_q : MEM_Size;
    assign eff_rw    = in_access ? rw_q   : MEM_RW;

    assign wr_en   = Clr_n & complete_c & (eff_rw == RW_STORE);
    assign Stall   = Clr_n & stall_c;
    assign DataOut = (Clr_n && complete_c && (eff_rw == RW_LOAD))
                   ? load_extend(eff_size, rd_word) : 32'h0000_0000;
    assign Busy    = busy_q;

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= SIZE_BYTE;
            rw_q    <= RW_LOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_ACCESS);
            if (latch_c) begin
                addr_q <= Address;
                data_q <= DataIn;
                size_q <= MEM_Size;
                rw_q   <= MEM_RW;
            end
        end
    end

    data_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (Clk),
        .wr_en   (wr_en),
        .wr_size (eff_size),
        .wr_addr (eff_addr),
        .wr_data (eff_data),
        .rd_addr (eff_addr),
        .rd_word (rd_word)
    );

endmodule

// File: tb/tb_data_memory_stage.sv
// Randomized bench for data_memory_stage: a 1-cycle and a 3-cycle instance checked
// every cycle against a transaction-level byte-array model.
module tb_data_memory_stage;
    import data_memory_stage_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        e1, e3;
    logic        rw_s, size_s;
    logic [7:0]  addr_s;
    logic [31:0] din_s;

    logic [31:0] dout1, dout3;
    logic        stall1, stall3, busy1, busy3;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  m1 [256];
    logic [7:0]  m3 [256];

    bit          chk_en = 1'b0;
    logic        exp_stall1, exp_busy1, exp_stall3, exp_busy3;
    logic [31:0] exp_dout1, exp_dout3;
    bit          chk_dout1, chk_dout3;

    always #5 clk = ~clk;

    data_memory_stage #(.ADDR_W(8), .LATENCY(1)) dut1 (
        .Clk(clk), .Clr_n(clr_n), .MEM_E(e1), .MEM_RW(rw_s), .MEM_Size(size_s),
        .Address(addr_s), .DataIn(din_s), .DataOut(dout1), .Stall(stall1), .Busy(busy1)
    );

    data_memory_stage #(.ADDR_W(8), .LATENCY(3)) dut3 (
        .Clk(clk), .Clr_n(clr_n), .MEM_E(e3), .MEM_RW(rw_s), .MEM_Size(size_s),
        .Address(addr_s), .DataIn(din_s), .DataOut(dout3), .Stall(stall3), .Busy(busy3)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input bit which, input logic size, input logic [7:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] idx;
            idx = a + 8'(k);
            w[31-8*k -: 8] = which ? m3[idx] : m1[idx];
        end
        return (size == SIZE_WORD) ? w : {24'h0, w[31:24]};
    endfunction

    task automatic mwrite(input bit which, input logic size, input logic [7:0] a, input logic [31:0] d);
        int n;
        n = (size == SIZE_WORD) ? 4 : 1;
        for (int k = 0; k < n; k++) begin
            logic [7:0] idx;
            logic [7:0] b;
            idx = a + 8'(k);
            b = (size == SIZE_WORD) ? d[31-8*k -: 8] : d[7:0];
            if (which) m3[idx] = b; else m1[idx] = b;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall1", {31'b0, stall1}, {31'b0, exp_stall1});
            check("busy1",  {31'b0, busy1},  {31'b0, exp_busy1});
            check("stall3", {31'b0, stall3}, {31'b0, exp_stall3});
            check("busy3",  {31'b0, busy3},  {31'b0, exp_busy3});
            if (chk_dout1) check("dout1", dout1, exp_dout1);
            if (chk_dout3) check("dout3", dout3, exp_dout3);
        end
    end

    task automatic set_idle_exp();
        exp_stall1 = 1'b0; exp_busy1 = 1'b0; exp_dout1 = 32'h0; chk_dout1 = 1'b1;
        exp_stall3 = 1'b0; exp_busy3 = 1'b0; exp_dout3 = 32'h0; chk_dout3 = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            e1 = 1'b0; e3 = 1'b0;
            rw_s = 1'($urandom); size_s = 1'($urandom);
            addr_s = 8'($urandom); din_s = $urandom;
            set_idle_exp();
            @(posedge clk); #1;
        end
    endtask

    task automatic acc1(input logic rw, input logic size, input logic [7:0] a,
                        input logic [31:0] d, input bit use_lit, input logic [31:0] lit);
        e1 = 1'b1; e3 = 1'b0;
        rw_s = rw; size_s = size; addr_s = a; din_s = d;
        set_idle_exp();
        exp_dout1 = (rw == RW_LOAD) ? mread(1'b0, size, a) : 32'h0;
        $display("txn L1 %s %s a=%02h d=%08h", rw ? "ST" : "LD", size ? "W" : "B", a, d);
        if (use_lit) begin
            @(negedge clk);
            check("lit1", dout1, lit);
        end
        @(posedge clk);
        if (rw == RW_STORE) mwrite(1'b0, size, a, d);
        #1;
        e1 = 1'b0;
        set_idle_exp();
    endtask

    task automatic acc3(input logic rw, input logic size, input logic [7:0] a,
                        input logic [31:0] d, input bit use_lit, input logic [31:0] lit);
        $display("txn L3 %s %s a=%02h d=%08h", rw ? "ST" : "LD", size ? "W" : "B", a, d);
        for (int k = 0; k < 3; k++) begin
            e1 = 1'b0; e3 = 1'b1;
            if (k == 1) begin
                // inputs are illegal to change while stalled; the DUT must ignore them
                rw_s = 1'($urandom); size_s = 1'($urandom);
                addr_s = 8'($urandom); din_s = $urandom;
            end else begin
                rw_s = rw; size_s = size; addr_s = a; din_s = d;
            end
            set_idle_exp();
            exp_stall3 = (k < 2);
            exp_busy3  = (k > 0);
            chk_dout3  = (k == 2) || (k == 0 && rw == RW_STORE);
            exp_dout3  = (k == 2 && rw == RW_LOAD) ? mread(1'b1, size, a) : 32'h0;
            if (k == 2 && use_lit) begin
                @(negedge clk);
                check("lit3", dout3, lit);
            end
            @(posedge clk);
            if (k == 2 && rw == RW_STORE) mwrite(1'b1, size, a, d);
            #1;
        end
        e3 = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n = 1'b0; e1 = 1'b0; e3 = 1'b0;
        rw_s = RW_LOAD; size_s = SIZE_BYTE; addr_s = '0; din_s = '0;
        set_idle_exp();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        clr_n = 1'b1;

        // preload whole arrays so any random address reads known data
        for (int i = 0; i < 64; i++) acc1(RW_STORE, SIZE_WORD, 8'(i * 4), $urandom, 1'b0, 32'h0);
        for (int i = 0; i < 64; i++) acc3(RW_STORE, SIZE_WORD, 8'(i * 4), $urandom, 1'b0, 32'h0);
        acc1(RW_STORE, SIZE_WORD, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        acc3(RW_STORE, SIZE_WORD, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        acc3(RW_STORE, SIZE_WORD, 8'h30, 32'h5A5AA5A5, 1'b0, 32'h0);
        check("model_pin_word", mread(1'b0, SIZE_WORD, 8'h10), 32'hDEADBEEF);
        check("model_pin_byte", mread(1'b1, SIZE_BYTE, 8'h12), 32'h000000BE);

        // single-cycle loads
        acc1(RW_LOAD, SIZE_WORD, 8'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        acc1(RW_LOAD, SIZE_BYTE, 8'h11, 32'h0, 1'b1, 32'h000000AD);

        // wrapping word store/load
        acc1(RW_STORE, SIZE_WORD, 8'hFE, 32'h11223344, 1'b0, 32'h0);
        acc1(RW_LOAD,  SIZE_WORD, 8'hFE, 32'h0, 1'b1, 32'h11223344);
        acc1(RW_LOAD,  SIZE_BYTE, 8'h00, 32'h0, 1'b1, 32'h00000033);
        acc1(RW_LOAD,  SIZE_BYTE, 8'h01, 32'h0, 1'b1, 32'h00000044);

        // multi-cycle load, then back-to-back store/load to the same byte
        acc3(RW_LOAD,  SIZE_WORD, 8'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        acc3(RW_STORE, SIZE_BYTE, 8'h20, 32'h000000AB, 1'b0, 32'h0);
        acc3(RW_LOAD,  SIZE_BYTE, 8'h20, 32'h0, 1'b1, 32'h000000AB);

        // reset in the middle of a pending store aborts it
        e1 = 1'b0; e3 = 1'b1;
        rw_s = RW_STORE; size_s = SIZE_WORD; addr_s = 8'h30; din_s = 32'hCAFEF00D;
        set_idle_exp();
        exp_stall3 = 1'b1;
        @(posedge clk); #1;
        clr_n = 1'b0;
        exp_stall3 = 1'b0; exp_busy3 = 1'b1;
        @(posedge clk); #1;
        clr_n = 1'b1; e3 = 1'b0;
        set_idle_exp();
        @(posedge clk); #1;
        acc3(RW_LOAD, SIZE_WORD, 8'h30, 32'h0, 1'b1, 32'h5A5AA5A5);

        // idle traffic must not disturb memory
        idle(20);
        acc1(RW_LOAD, SIZE_WORD, 8'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        acc3(RW_LOAD, SIZE_WORD, 8'h10, 32'h0, 1'b1, 32'hDEADBEEF);

        // randomized mixed traffic
        for (int i = 0; i < 200; i++) begin
            logic rw, sz;
            logic [7:0] a;
            logic [31:0] d;
            rw = 1'($urandom); sz = 1'($urandom);
            a = 8'($urandom); d = $urandom;
            if ($urandom_range(1, 0) == 1) acc3(rw, sz, a, d, 1'b0, 32'h0);
            else acc1(rw, sz, a, d, 1'b0, 32'h0);
            if ($urandom_range(3, 0) == 0) idle(1);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
